// File: rtl/pixel_uart_unpacker.sv
// -----------------------------------------------------------------------------
// pixel_uart_unpacker
//
// Receives 8N1 UART bytes and unpacks each one into eight binary pixels that
// are streamed, one per accepted handshake, to a pixel serial loader.
//
// The receive side is never stalled. A completed byte goes into a one-byte
// holding stage. If that stage is still busy when the next byte completes,
// the new byte is dropped and overrun_error is raised.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit period (>= 4)
//   MSB_FIRST    : 0 streams received bit 0 first, 1 streams bit 7 first
//
// Ports
//   clk             : single clock, rising edge
//   rst_n           : asynchronous active-low reset
//   uart_rx         : asynchronous serial input, idle high
//   pixel_bit       : current pixel (0 when nothing is held)
//   pixel_bit_valid : pixel_bit is valid
//   pixel_bit_ready : loader accepts pixel_bit this cycle
//   framing_error   : sticky, a stop bit was sampled low
//   overrun_error   : sticky, a byte was dropped because the hold was busy
//   err_clear       : synchronous pulse that clears both sticky flags
// -----------------------------------------------------------------------------
module pixel_uart_unpacker #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic pixel_bit,
    output logic pixel_bit_valid,
    input  logic pixel_bit_ready,
    output logic framing_error,
    output logic overrun_error,
    input  logic err_clear
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Last count of a full bit period, and the half-period point used to
    // re-check the start bit near its centre.
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } rx_state_e;

    // -------------------------------------------------------------------------
    // Input synchronizer
    // -------------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its inputs regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM: state register
    // -------------------------------------------------------------------------
    rx_state_e state_q;
    rx_state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic [CNT_W-1:0] baud_cnt_q;
    logic [CNT_W-1:0] baud_cnt_d;
    logic [2:0]       bit_cnt_q;
    logic [2:0]       bit_cnt_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;

    logic baud_mid;
    logic baud_last;

    assign baud_mid  = (baud_cnt_q == BAUD_MID);
    assign baud_last = (baud_cnt_q == BAUD_LAST);

    // -------------------------------------------------------------------------
    // Receive FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // A line that is high again at mid-start was only a glitch.
                if (baud_mid) state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: begin
                if (baud_last && (bit_cnt_q == 3'd7)) state_d = STOP;
            end
            STOP: begin
                if (baud_last) state_d = rx_s_q ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Receive FSM: outputs and datapath next-state
    // -------------------------------------------------------------------------
    logic byte_done;
    logic framing_set;

    always_comb begin
        baud_cnt_d  = baud_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        framing_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
            START: begin
                if (baud_mid) baud_cnt_d = '0;
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_d         = '0;
                    shift_d[bit_cnt_q] = rx_s_q;
                    // Wraps 7 -> 0 as the last data bit is taken.
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (rx_s_q) byte_done   = 1'b1;
                    else        framing_set = 1'b1;
                end
            end
            BREAK_WAIT: begin
                baud_cnt_d = '0;
            end
            default: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output holding stage
    // -------------------------------------------------------------------------
    logic [7:0] hold_byte_q;
    logic [7:0] hold_byte_d;
    logic       hold_full_q;
    logic       hold_full_d;
    logic [2:0] out_idx_q;
    logic [2:0] out_idx_d;

    logic handshake;
    logic last_accept;
    logic hold_load;
    logic overrun_set;

    assign handshake   = hold_full_q && pixel_bit_ready;
    assign last_accept = handshake && (out_idx_q == 3'd7);

    // A new byte may enter when the hold is empty or is emptied this cycle.
    assign hold_load   = byte_done && (!hold_full_q || last_accept);
    assign overrun_set = byte_done && !hold_load;

    always_comb begin
        hold_byte_d = hold_byte_q;
        hold_full_d = hold_full_q;
        out_idx_d   = out_idx_q;
        if (hold_load) begin
            hold_byte_d = shift_q;
            hold_full_d = 1'b1;
            out_idx_d   = 3'd0;
        end else if (handshake) begin
            if (out_idx_q == 3'd7) begin
                hold_full_d = 1'b0;
                out_idx_d   = 3'd0;
            end else begin
                out_idx_d = out_idx_q + 3'd1;
            end
        end
    end

    // NOTE: the hold register is reset even though hold_full gates its use,
    // so a reset mid-stream leaves no stale pixel data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_byte_q <= '0;
            hold_full_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            hold_byte_q <= hold_byte_d;
            hold_full_q <= hold_full_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // For MSB-first streaming, ~out_idx equals 7 - out_idx on 3 bits.
    logic [2:0] sel_idx;

    assign sel_idx         = MSB_FIRST ? ~out_idx_q : out_idx_q;
    assign pixel_bit       = hold_full_q & hold_byte_q[sel_idx];
    assign pixel_bit_valid = hold_full_q;

    // -------------------------------------------------------------------------
    // Sticky error flags: a set event in the same cycle beats err_clear.
    // -------------------------------------------------------------------------
    logic framing_error_q;
    logic framing_error_d;
    logic overrun_error_q;
    logic overrun_error_d;

    always_comb begin
        framing_error_d = framing_error_q;
        overrun_error_d = overrun_error_q;
        if (err_clear) begin
            framing_error_d = 1'b0;
            overrun_error_d = 1'b0;
        end
        if (framing_set) framing_error_d = 1'b1;
        if (overrun_set) overrun_error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            framing_error_q <= framing_error_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;

endmodule

// File: doc/pixel_uart_unpacker.md
PIXEL_UART_UNPACKER -- requirements
Module: pixel_uart_unpacker

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clock cycles per UART bit period; legal values are integers >= 4.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 emits received byte bit 0 first, 1 emits bit 7 first.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, 8N1 framing, idle high.
REQ-006 SHALL have port pixel_bit  output  1  current binary pixel presented to the pixel serial loader.
REQ-007 SHALL have port pixel_bit_valid  output  1  pixel_bit is valid.
REQ-008 SHALL have port pixel_bit_ready  input  1  loader accepts pixel_bit this cycle.
REQ-009 SHALL have port framing_error  output  1  sticky flag: a stop bit was sampled low.
REQ-010 SHALL have port overrun_error  output  1  sticky flag: a received byte was dropped because the holding register was busy.
REQ-011 SHALL have port err_clear  input  1  synchronous pulse that clears both sticky flags.

Function
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value rx_s.
REQ-013 SHALL implement receive FSM states IDLE, START, DATA, STOP, BREAK_WAIT, with one baud counter (0..CLKS_PER_BIT-1) and one 3-bit data-bit counter.
REQ-014 In IDLE, rx_s==0 SHALL move the FSM to START and clear the baud counter.
REQ-015 In START, at baud count CLKS_PER_BIT/2-1 (integer division), rx_s==0 SHALL move the FSM to DATA and clear the counter; rx_s==1 SHALL return the FSM to IDLE as a glitch with no other effect.
REQ-016 In DATA, rx_s SHALL be sampled each time the baud counter reaches CLKS_PER_BIT-1; sample k (k=0..7) goes to shift-register bit k (UART LSB-first); after the 8th sample the FSM moves to STOP.
REQ-017 In STOP, at baud count CLKS_PER_BIT-1, rx_s==1 SHALL raise a one-cycle byte_done and move the FSM to IDLE; rx_s==0 SHALL set framing_error, discard the byte, and move the FSM to BREAK_WAIT.
REQ-018 BREAK_WAIT SHALL move to IDLE on the first cycle with rx_s==1.
REQ-019 Output holding stage: 8-bit hold_byte, hold_full flag, 3-bit out_idx; pixel_bit_valid SHALL equal hold_full.
REQ-020 pixel_bit SHALL equal hold_byte[out_idx] when MSB_FIRST=0 and hold_byte[7-out_idx] when MSB_FIRST=1; pixel_bit SHALL be 0 when hold_full=0.
REQ-021 On pixel_bit_valid && pixel_bit_ready, out_idx SHALL increment; when out_idx==7, hold_full SHALL clear and out_idx SHALL wrap to 0.
REQ-022 On byte_done, the shift register SHALL load into hold_byte, with hold_full=1 and out_idx=0 on the next edge, if hold_full==0 or the final-bit handshake (out_idx==7 accepted) occurs in the same cycle.
REQ-023 Otherwise byte_done SHALL set overrun_error and drop the new byte; the held byte SHALL be unaffected.
REQ-024 Latency: pixel_bit_valid SHALL rise on the cycle after the stop-bit sample edge; bits SHALL stream one per cycle while ready is held high.
REQ-025 pixel_bit and pixel_bit_valid SHALL hold stable while valid && !ready.
REQ-026 err_clear SHALL clear both flags; if a set event coincides with err_clear, set SHALL win.
REQ-027 The receive FSM SHALL never stall on output backpressure.

Reset
REQ-028 While rst_n==0: FSM=IDLE, counters=0, synchronizer=1, hold_byte=0, hold_full=0, pixel_bit=0, pixel_bit_valid=0, framing_error=0, overrun_error=0.
REQ-029 Reset asserted mid-byte SHALL discard the partial byte and any held byte; after release, reception SHALL resume on the next falling edge of rx_s.

Verification (CLKS_PER_BIT=4)
REQ-030 Send 0x0F with MSB_FIRST=0 and ready=1 -> pixel_bit = 1,1,1,1,0,0,0,0 on 8 consecutive valid cycles, then valid=0.
REQ-031 Send 0x0F with MSB_FIRST=1 -> pixel_bit = 0,0,0,0,1,1,1,1.
REQ-032 ready=0, send 0x81 then 0x7E -> overrun_error=1, valid stays 1 with pixel_bit=1 (bit 0 of 0x81); release ready -> 1,0,0,0,0,0,0,1 is emitted, and 0x7E never appears.
REQ-033 Frame 0x55 with a low stop bit, line held low 10 cycles -> no valid, framing_error=1, FSM in BREAK_WAIT; line high then 0x55 -> 1,0,1,0,1,0,1,0; err_clear -> framing_error=0.
REQ-034 uart_rx low for 1 cycle -> no valid, no error flags.
REQ-035 rst_n pulsed low after the 4th data bit of 0xFF -> all outputs 0; next 0x3C -> 0,0,1,1,1,1,0,0.
